uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter WIDTH, default 8: character width in bits.
REQ-003 Parameter RETRY_CYCLES, default 4: cycles to wait for tx_rdy to fall before reissuing.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 in_valid  input  NUM_PORTS: per-port character offered.
REQ-007 in_data  input  NUM_PORTS*WIDTH: port i character at bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  NUM_PORTS: per-port holding slot empty.
REQ-009 tx_rdy  input  1: rdy from the shared uart_tx.
REQ-010 tx_new_data  output  1: one-cycle start strobe to uart_tx.
REQ-011 tx_char  output  WIDTH: character presented to uart_tx.
REQ-012 cur_port  output  3: index of port granted most recently.
REQ-013 busy  output  1: high in any state other than IDLE.

Function
REQ-014 Each port SHALL own a one-entry holding register and full flag; in_ready[i] = !full[i], driven directly from the registered flag.
REQ-015 A transfer occurs on an edge where in_valid[i] and in_ready[i] are both high; data is captured and full[i] is set.
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-017 IDLE: when any full flag is set and tx_rdy=1, select a winner round-robin starting at ptr+1 with wrap, load tx_char, clear the winner's full flag, set cur_port and ptr to the winner, and go to ISSUE.
REQ-018 ISSUE: tx_new_data=1 for exactly this cycle, then go to WAIT_LOW.
REQ-019 WAIT_LOW: on tx_rdy=0 go to WAIT_HIGH; if tx_rdy stays 1 for RETRY_CYCLES cycles, return to ISSUE (reissue the same char).
REQ-020 WAIT_HIGH: on tx_rdy=1 go to IDLE.
REQ-021 tx_char SHALL be stable from ISSUE entry until WAIT_HIGH exit.
REQ-022 Latency: with IDLE, tx_rdy=1 and no other full port, tx_new_data rises in the second cycle after the accepting edge.
REQ-023 A port whose full flag is cleared on an edge SHALL show in_ready=1 on the next cycle and may refill while its previous char is still transmitting.
REQ-024 All ports full: grants rotate in strict order; no port is granted twice while another port is full.
REQ-025 In IDLE with tx_rdy=0, no grant is made and full flags are held.
REQ-026 NUM_PORTS*WIDTH arithmetic is unsigned; ptr wraps from NUM_PORTS-1 to 0.

Reset
REQ-027 While rst_n=0: state=IDLE, all full flags=0, ptr=NUM_PORTS-1 (port 0 first), tx_new_data=0, tx_char=0, cur_port=0, busy=0, in_ready all 1.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight characters without any further strobe.

Structure
REQ-029 Package uart_hub_pkg SHALL hold the FSM state encoding, the CLOG2 constant function, and the default WIDTH/NUM_PORTS values.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, ptr; outputs: grant index, any_grant).

Verification
REQ-031 Single port: port 1 sends 0xA5 with an idle uart_tx model -> exactly one tx_new_data pulse, tx_char=0xA5, cur_port=1.
REQ-032 All four ports are loaded in the same cycle (0x10,0x11,0x12,0x13) -> transmit order port 0,1,2,3 after reset.
REQ-033 Fairness: ports 0 and 2 are reloaded continuously -> grants alternate 0,2,0,2.
REQ-034 tx_rdy is held at 1 after a strobe -> the strobe reissues after 4 cycles with the same tx_char.
REQ-035 rst_n is asserted during WAIT_HIGH with two ports full -> all outputs take their reset values immediately and no strobe follows release.

Source files
------------

// File: rtl/uart_hub_pkg.sv
// rtl/uart_hub_pkg.sv - shared types, defaults and helpers for the UART transmit hub
// Contents:
//   DEFAULT_WIDTH / DEFAULT_NUM_PORTS / DEFAULT_RETRY_CYCLES - parameter defaults
//   state_e - arbiter FSM state encoding
//   CLOG2   - constant ceil(log2) used to size pointers and counters
package uart_hub_pkg;

  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_NUM_PORTS    = 4;
  localparam int DEFAULT_RETRY_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } state_e;

  function automatic int CLOG2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin selector
// Ports:
//   req       in  NUM_PORTS  request vector (one bit per port)
//   ptr       in  PTR_W      most recently granted index; search starts at ptr+1
//   grant_idx out PTR_W      index of the selected requester (0 when none)
//   any_grant out 1          at least one request is present
module rr_arbiter
  import uart_hub_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int PTR_W     = CLOG2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [PTR_W-1:0]     grant_idx,
  output logic                 any_grant
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    idx       = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Scan from the farthest offset down to ptr+1 so the nearest requester
    // after ptr is the last writer and therefore wins. Offset NUM_PORTS is
    // ptr itself, which only wins when it is the sole requester.
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_PORTS);
      if (req[idx]) begin
        grant_idx = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one uart_tx among NUM_PORTS character sources
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   in_valid     in  NUM_PORTS        per-port character offered
//   in_data      in  NUM_PORTS*WIDTH  port i character at [i*WIDTH +: WIDTH]
//   in_ready     out NUM_PORTS        per-port holding slot empty
//   tx_rdy       in  1                ready from the shared uart_tx
//   tx_new_data  out 1                one-cycle start strobe to uart_tx
//   tx_char      out WIDTH            character presented to uart_tx
//   cur_port     out 3                most recently granted port
//   busy         out 1                FSM not in IDLE
module uart_tx_arbiter
  import uart_hub_pkg::*;
#(
  parameter int NUM_PORTS    = DEFAULT_NUM_PORTS,
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int RETRY_CYCLES = DEFAULT_RETRY_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]       in_ready,
  input  logic                       tx_rdy,
  output logic                       tx_new_data,
  output logic [WIDTH-1:0]           tx_char,
  output logic [2:0]                 cur_port,
  output logic                       busy
);

  localparam int PTR_W = CLOG2(NUM_PORTS);
  localparam int CNT_W = CLOG2(RETRY_CYCLES + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RETRY_CYCLES - 1);

  state_e                         state_q, state_d;
  logic [NUM_PORTS-1:0]           full_q, full_d;
  logic [NUM_PORTS-1:0][WIDTH-1:0] hold_q, hold_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [2:0]                     cur_port_q, cur_port_d;
  logic [WIDTH-1:0]               tx_char_q, tx_char_d;
  logic [CNT_W-1:0]               retry_q, retry_d;

  logic [PTR_W-1:0]               grant_idx;
  logic                           any_grant;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req       (full_q),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    hold_d     = hold_q;
    ptr_d      = ptr_q;
    cur_port_d = cur_port_q;
    tx_char_d  = tx_char_q;
    retry_d    = retry_q;

    // Capture only into empty slots; a slot being granted this edge is full,
    // so capture and grant never touch the same port on one edge.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i] && !full_q[i]) begin
        full_d[i] = 1'b1;
        hold_d[i] = in_data[i*WIDTH +: WIDTH];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (any_grant && tx_rdy) begin
          tx_char_d         = hold_q[grant_idx];
          full_d[grant_idx] = 1'b0;
          ptr_d             = grant_idx;
          cur_port_d        = 3'(grant_idx);
          state_d           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        retry_d = '0;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // uart_tx missed the strobe if rdy never drops; strobe the same char again.
        if (!tx_rdy) begin
          state_d = ST_WAIT_HIGH;
        end else if (retry_q == CNT_LAST) begin
          state_d = ST_ISSUE;
        end else begin
          retry_d = retry_q + CNT_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (tx_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      full_q     <= '0;
      hold_q     <= '0;
      ptr_q      <= PTR_LAST;
      cur_port_q <= '0;
      tx_char_q  <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      hold_q     <= hold_d;
      ptr_q      <= ptr_d;
      cur_port_q <= cur_port_d;
      tx_char_q  <= tx_char_d;
      retry_q    <= retry_d;
    end
  end

  assign in_ready    = ~full_q;
  assign tx_new_data = (state_q == ST_ISSUE);
  assign tx_char     = tx_char_q;
  assign cur_port    = cur_port_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
